// File: rtl/fp_pkg.sv
// Shared floating-point constants: flag bit positions, rounding encodings, operand classes and special-value builders.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_INVALID
    } fpClass_e;

    function automatic int fpBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    function automatic logic [63:0] fpMask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Builders return a 64-bit container; callers slice to their word width.
    function automatic logic [63:0] fpPack(input logic sign, input int expW, input int manW,
                                           input logic [63:0] expF, input logic [63:0] manF);
        return ({63'd0, sign} << (expW + manW)) | ((expF & fpMask(expW)) << manW) | (manF & fpMask(manW));
    endfunction

    function automatic logic [63:0] fpQnan(input int expW, input int manW);
        return fpPack(1'b0, expW, manW, fpMask(expW), 64'd1 << (manW - 1));
    endfunction

    function automatic logic [63:0] fpInf(input logic sign, input int expW, input int manW);
        return fpPack(sign, expW, manW, fpMask(expW), 64'd0);
    endfunction

    function automatic logic [63:0] fpMaxFinite(input logic sign, input int expW, input int manW);
        return fpPack(sign, expW, manW, fpMask(expW) - 64'd1, fpMask(manW));
    endfunction

endpackage

// File: rtl/vedic_mult_pipe.sv
// Unsigned NxN multiplier using Urdhva-Tiryagbhyam column sums, product registered.
// Latency: 1 cycle. Backpressure: output register holds while en is low.
module vedic_mult_pipe #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  colSum [2*N-1];
    logic [2*N-1:0] term;
    logic [2*N-1:0] prodComb;

    // Vertical-and-crosswise: column k collects every x[i]&y[j] with i+j == k.
    always_comb begin
        term     = '0;
        prodComb = '0;
        for (int k = 0; k < 2*N-1; k++) begin
            colSum[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                colSum[i+j] = colSum[i+j] + CW'(x[i] & y[j]);
            end
        end
        for (int k = 0; k < 2*N-1; k++) begin
            term          = '0;
            term[CW-1:0]  = colSum[k];
            prodComb      = prodComb + (term << k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= prodComb;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// IEEE-style FP multiplier: unpack/classify, mantissa product, normalise/round/pack.
// Latency: 3 cycles, one result per cycle. Backpressure: whole pipe holds when out_valid && !out_ready.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int  EXP_W = FP_EXP_W,
    parameter int  MAN_W = FP_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int N    = MAN_W + 1;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = fpBias(EXP_W);

    localparam logic [W-1:0]         QNAN    = W'(fpQnan(EXP_W, MAN_W));
    localparam logic [W-1:0]         POS_INF = W'(fpInf(1'b0, EXP_W, MAN_W));
    localparam logic [W-1:0]         POS_MAX = W'(fpMaxFinite(1'b0, EXP_W, MAN_W));
    localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);

    logic adv;

    assign in_ready = out_ready || !out_valid;
    assign adv      = in_ready;

    // ---------------- S1: unpack, classify, sign, exponent sum ----------------
    logic               signA, signB;
    logic [EXP_W-1:0]   expA, expB;
    logic [MAN_W-1:0]   manA, manB;
    logic               aZero, bZero, aInf, bInf, aNan, bNan;
    fpClass_e           cls1;
    logic signed [XW-1:0] expSum1;

    assign {signA, expA, manA} = a;
    assign {signB, expB, manB} = b;

    assign aZero = (expA == '0);
    assign bZero = (expB == '0);
    assign aInf  = (expA == '1) && (manA == '0);
    assign bInf  = (expB == '1) && (manB == '0);
    assign aNan  = (expA == '1) && (manA != '0);
    assign bNan  = (expB == '1) && (manB != '0);

    assign expSum1 = $signed(XW'(expA) + XW'(expB) - XW'(BIAS));

    always_comb begin
        cls1 = CLS_NORMAL;
        if (aNan || bNan) begin
            cls1 = CLS_NAN;
        end else if ((aInf && bZero) || (aZero && bInf)) begin
            cls1 = CLS_INVALID;
        end else if (aInf || bInf) begin
            cls1 = CLS_INF;
        end else if (aZero || bZero) begin
            cls1 = CLS_ZERO;
        end
    end

    logic                 s1Vld, s1Sign, s1Rnd;
    logic signed [XW-1:0] s1Exp;
    fpClass_e             s1Cls;
    logic [N-1:0]         s1ManA, s1ManB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Vld  <= 1'b0;
            s1Sign <= 1'b0;
            s1Rnd  <= RND_RNE;
            s1Exp  <= '0;
            s1Cls  <= CLS_NORMAL;
            s1ManA <= '0;
            s1ManB <= '0;
        end else if (adv) begin
            s1Vld  <= in_valid;
            s1Sign <= signA ^ signB;
            s1Rnd  <= rnd_mode;
            s1Exp  <= expSum1;
            s1Cls  <= cls1;
            s1ManA <= {1'b1, manA};
            s1ManB <= {1'b1, manB};
        end
    end

    // ---------------- S2: mantissa product ----------------
    logic [2*N-1:0]       prod2;
    logic                 s2Vld, s2Sign, s2Rnd;
    logic signed [XW-1:0] s2Exp;
    fpClass_e             s2Cls;

    vedic_mult_pipe #(.N(N)) uMult (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .x   (s1ManA),
        .y   (s1ManB),
        .p   (prod2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Vld  <= 1'b0;
            s2Sign <= 1'b0;
            s2Rnd  <= RND_RNE;
            s2Exp  <= '0;
            s2Cls  <= CLS_NORMAL;
        end else if (adv) begin
            s2Vld  <= s1Vld;
            s2Sign <= s1Sign;
            s2Rnd  <= s1Rnd;
            s2Exp  <= s1Exp;
            s2Cls  <= s1Cls;
        end
    end

    // ---------------- S3: normalise, round, range check, pack ----------------
    logic                 prodHi;
    logic [2*N-2:0]       normP;
    logic [MAN_W-1:0]     keepMan;
    logic                 guardBit, stickyBit, roundUp, inexact;
    logic [MAN_W:0]       manRnd;
    logic signed [XW-1:0] expNorm, expFin;
    logic [W-1:0]         res3;
    logic [3:0]           flg3;

    // Product of two [1,2) mantissas lies in [1,4); a set MSB means >= 2.0.
    assign prodHi    = prod2[2*N-1];
    assign normP     = prodHi ? prod2[2*N-2:0] : {prod2[2*N-3:0], 1'b0};
    assign keepMan   = normP[2*N-2 -: MAN_W];
    assign guardBit  = normP[MAN_W];
    assign stickyBit = |normP[MAN_W-1:0];
    assign inexact   = guardBit || stickyBit;
    assign roundUp   = (s2Rnd == RND_RNE) && guardBit && (stickyBit || keepMan[0]);
    assign manRnd    = {1'b0, keepMan} + (MAN_W+1)'(roundUp);
    assign expNorm   = s2Exp + XW'(prodHi);
    assign expFin    = expNorm + XW'(manRnd[MAN_W]);

    always_comb begin
        res3 = '0;
        flg3 = '0;
        case (s2Cls)
            CLS_NAN: begin
                res3 = QNAN;
            end
            CLS_INVALID: begin
                res3                = QNAN;
                flg3[FLAG_INVALID]  = 1'b1;
            end
            CLS_INF: begin
                res3 = {s2Sign, POS_INF[W-2:0]};
            end
            CLS_ZERO: begin
                res3 = {s2Sign, {(W-1){1'b0}}};
            end
            default: begin
                if (expFin >= EXP_OVF) begin
                    res3 = (s2Rnd == RND_RNE) ? {s2Sign, POS_INF[W-2:0]} : {s2Sign, POS_MAX[W-2:0]};
                    flg3[FLAG_OVERFLOW] = 1'b1;
                    flg3[FLAG_INEXACT]  = 1'b1;
                end else if (expFin[XW-1] || (expFin == '0)) begin
                    res3 = {s2Sign, {(W-1){1'b0}}};
                    flg3[FLAG_UNDERFLOW] = 1'b1;
                    flg3[FLAG_INEXACT]   = 1'b1;
                end else begin
                    // A rounding carry leaves manRnd's low bits at zero, which is the correct mantissa.
                    res3 = {s2Sign, expFin[EXP_W-1:0], manRnd[MAN_W-1:0]};
                    flg3[FLAG_INEXACT] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= s2Vld;
            if (s2Vld) begin
                result <= res3;
                flags  <= flg3;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: hand-computed single-precision vectors, stall streaming, mid-flight reset.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int tests  = 0;
    int failed = 0;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // One isolated operation: checks 3-cycle latency, result and flags, then lets it drain.
    task automatic runOne(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                          input logic rm, input logic [31:0] wantRes, input logic [3:0] wantFlg);
        int n;
        a         = opA;
        b         = opB;
        rnd_mode  = rm;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_result"}, result, wantRes);
        chk({tag, "_flags"}, flags, wantFlg);
        @(posedge clk); #1;
    endtask

    initial begin
        int          sent;
        int          recv;
        int          stallSeen;
        logic [31:0] prevRes;
        logic        prevStall;
        logic        acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        rnd_mode  = 1'b0;
        out_ready = 1'b1;

        #2;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", flags, 4'h0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // flags = {invalid, overflow, underflow, inexact}
        runOne("mul_1p5_x_2",   32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        runOne("rne_inexact",   32'h3FC00001, 32'h3FC00000, 1'b0, 32'h40100001, 4'b0001);
        runOne("trunc_inexact", 32'h3FC00001, 32'h3FC00000, 1'b1, 32'h40100000, 4'b0001);
        runOne("ovf_rne",       32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101);
        runOne("ovf_trunc",     32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101);
        runOne("underflow",     32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011);
        runOne("inf_x_zero",    32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);
        runOne("neg_inf_x_2",   32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000);
        runOne("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        runOne("neg_zero",      32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 4'b0000);
        runOne("tie_odd_up",    32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001);
        runOne("tie_even_stay", 32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 4'b0001);
        runOne("round_carry",   32'h3F800001, 32'h3FFFFFFE, 1'b0, 32'h40000000, 4'b0001);
        runOne("carry_trunc",   32'h3F800001, 32'h3FFFFFFE, 1'b1, 32'h3FFFFFFF, 4'b0001);

        // Stream 2^i * 3.0 = {0, 128+i, 0x400000}, with out_ready low for cycles 6..10.
        sent      = 0;
        recv      = 0;
        stallSeen = 0;
        prevStall = 1'b0;
        prevRes   = '0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            in_valid  = (sent < 10);
            a         = {1'b0, 8'(127 + sent), 23'h0};
            b         = 32'h40400000;
            rnd_mode  = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                stallSeen++;
                chk("stall_in_ready", in_ready, 1'b0);
                if (prevStall) chk("stall_hold", result, prevRes);
            end
            if (out_valid && out_ready) begin
                chk("stream_order", result, {1'b0, 8'(128 + recv), 23'h400000});
                recv++;
            end
            acc       = in_valid && in_ready;
            prevStall = out_valid && !out_ready;
            prevRes   = result;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", recv, 10);
        chk("stall_cycles", stallSeen, 5);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stream_no_dup", out_valid, 1'b0);
        end

        // Three operations in flight, then reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a        = {1'b0, 8'(130 + k), 23'h0};
            b        = 32'h40400000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        runOne("post_rst", 32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
